// File: rtl/fdiv_seq_ctrl_if.sv
// Decode/divider-side signal bundle for the FP divide sequencer.
// master = CPU decode/pipeline side, slave = the sequencer itself.
interface fdiv_seq_ctrl_if;
    logic       fdiv;
    logic [4:0] fd;
    logic       pipe_enable;
    logic [4:0] fs;
    logic [4:0] ft;
    logic       use_fs;
    logic       use_ft;
    logic       div_start;
    logic       div_enable;
    logic       stall;
    logic       busy;
    logic [4:0] count;
    logic       wb_valid;
    logic [4:0] wb_fd;

    modport master (
        output fdiv, fd, pipe_enable, fs, ft, use_fs, use_ft,
        input  div_start, div_enable, stall, busy, count, wb_valid, wb_fd
    );

    modport slave (
        input  fdiv, fd, pipe_enable, fs, ft, use_fs, use_ft,
        output div_start, div_enable, stall, busy, count, wb_valid, wb_fd
    );
endinterface

// File: rtl/fdiv_seq_ctrl.sv
// Sequencer for a multi-cycle Newton FP divider: launches a divide, runs the
// fixed iteration phase, drains the exponent/flag pipe and flags writeback.
module fdiv_seq_ctrl #(
    parameter int ITER_CYCLES = 8,
    parameter int PIPE_DEPTH  = 3
) (
    input  logic               clock,
    input  logic               resetn,
    fdiv_seq_ctrl_if.slave     bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [4:0] ITER_LAST  = 5'(ITER_CYCLES - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(PIPE_DEPTH - 1);

    state_e     state_q, state_d;
    logic [4:0] iter_cnt_q, iter_cnt_d;
    logic [2:0] drain_cnt_q, drain_cnt_d;
    logic [4:0] fd_reg_q, fd_reg_d;

    logic start_c;
    logic wb_c;
    logic den_c;
    logic stall_c;
    logic hazard_c;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            iter_cnt_q  <= 5'd0;
            drain_cnt_q <= 3'd0;
            fd_reg_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            iter_cnt_q  <= iter_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            fd_reg_q    <= fd_reg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        iter_cnt_d  = iter_cnt_q;
        drain_cnt_d = drain_cnt_q;
        fd_reg_d    = fd_reg_q;
        start_c     = 1'b0;
        wb_c        = 1'b0;
        den_c       = 1'b0;
        stall_c     = 1'b0;
        hazard_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                den_c = bus.pipe_enable;
                // A launch only happens on an advancing pipe; a frozen pipe keeps the divide in decode.
                if (bus.fdiv && bus.pipe_enable) begin
                    start_c    = 1'b1;
                    stall_c    = 1'b1;
                    fd_reg_d   = bus.fd;
                    iter_cnt_d = ITER_LAST;
                    state_d    = S_ITER;
                end
            end

            S_ITER: begin
                // Iteration is self-timed inside the core, so it ignores pipe_enable.
                stall_c = 1'b1;
                if (iter_cnt_q == 5'd0) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = DRAIN_LAST;
                end else begin
                    iter_cnt_d = iter_cnt_q - 5'd1;
                end
            end

            S_DRAIN: begin
                den_c    = bus.pipe_enable;
                hazard_c = (bus.use_fs && (bus.fs == fd_reg_q)) ||
                           (bus.use_ft && (bus.ft == fd_reg_q));
                stall_c  = bus.fdiv || hazard_c;
                // The drain pipe shares the CPU's enable, so it only moves on advancing cycles.
                if (bus.pipe_enable) begin
                    if (drain_cnt_q == 3'd0) begin
                        wb_c    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 3'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset gates the combinational outputs so input activity cannot leak through while held.
    assign bus.div_start  = resetn & start_c;
    assign bus.div_enable = resetn & den_c;
    assign bus.stall      = resetn & stall_c;
    assign bus.wb_valid   = resetn & wb_c;
    assign bus.busy       = resetn & (state_q != S_IDLE);
    assign bus.count      = (state_q == S_ITER) ? iter_cnt_q : 5'd0;
    assign bus.wb_fd      = fd_reg_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// Bench for fdiv_seq_ctrl: directed scenarios plus random stimulus, checked
// per cycle against an elapsed-time reference model and a writeback queue.
module tb_fdiv_seq_ctrl;

    localparam int ITER_CYCLES = 8;
    localparam int PIPE_DEPTH  = 3;

    logic       clock;
    logic       resetn;
    logic [1:0] dbg_state;

    fdiv_seq_ctrl_if bus ();

    fdiv_seq_ctrl #(
        .ITER_CYCLES (ITER_CYCLES),
        .PIPE_DEPTH  (PIPE_DEPTH)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];

    // reference model: a divide in flight is described by its launch cycle
    // and how many advancing cycles it has spent in the drain phase
    int         cyc      = 0;
    bit         inflight = 0;
    int         t_launch = 0;
    int         drain_en = 0;
    logic [4:0] fd_m     = 5'd0;

    bit         mon_en = 0;
    bit         e_start, e_den, e_stall, e_busy, e_wb;
    logic [4:0] e_count, e_fd;

    bit         p_valid = 0;
    bit         p_rst, p_start, p_drain, p_pe, p_wb;
    logic [4:0] p_fd;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rst_a, input bit f, input logic [4:0] d, input bit pe,
                        input logic [4:0] s, input logic [4:0] t, input bit us, input bit ut);
        int el;
        @(posedge clock);
        #1;
        if (p_valid && p_rst) begin
            if (p_start) begin
                inflight = 1;
                t_launch = cyc;
                drain_en = 0;
                fd_m     = p_fd;
                exp_q.push_back(p_fd);
            end
            if (p_drain && p_pe) drain_en++;
            if (p_wb) inflight = 0;
        end
        cyc++;

        resetn          = rst_a;
        bus.fdiv        = f;
        bus.fd          = d;
        bus.pipe_enable = pe;
        bus.fs          = s;
        bus.ft          = t;
        bus.use_fs      = us;
        bus.use_ft      = ut;

        e_start = 0; e_den = 0; e_stall = 0; e_busy = 0; e_wb = 0; e_count = 5'd0;
        p_drain = 0;
        if (!rst_a) begin
            inflight = 0;
            drain_en = 0;
            fd_m     = 5'd0;
            exp_q.delete();
        end else if (!inflight) begin
            e_start = f && pe;
            e_stall = f && pe;
            e_den   = pe;
        end else begin
            el     = cyc - t_launch;
            e_busy = 1;
            if (el <= ITER_CYCLES) begin
                e_stall = 1;
                e_count = 5'(ITER_CYCLES - el);
            end else begin
                p_drain = 1;
                e_den   = pe;
                e_stall = f || (us && s == fd_m) || (ut && t == fd_m);
                e_wb    = pe && (drain_en == PIPE_DEPTH - 1);
            end
        end
        e_fd = fd_m;

        p_valid = 1;
        p_rst   = rst_a;
        p_start = e_start;
        p_pe    = pe;
        p_wb    = e_wb;
        p_fd    = d;
        mon_en  = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 5'd0, 1, 5'd0, 5'd0, 0, 0);
    endtask

    // monitor: per-cycle control outputs against the model, writeback against the queue
    always @(negedge clock) begin
        if (mon_en) begin
            chk("div_start", 5'(bus.div_start), 5'(e_start));
            chk("div_enable", 5'(bus.div_enable), 5'(e_den));
            chk("stall", 5'(bus.stall), 5'(e_stall));
            chk("busy", 5'(bus.busy), 5'(e_busy));
            chk("wb_valid", 5'(bus.wb_valid), 5'(e_wb));
            chk("count", bus.count, e_count);
            chk("wb_fd", bus.wb_fd, e_fd);
            if (bus.wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 5'd1, 5'd0);
                end else begin
                    chk("wb_queue_fd", bus.wb_fd, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [4:0] r_fs;
        resetn          = 1'b0;
        bus.fdiv        = 1'b0;
        bus.fd          = 5'd0;
        bus.pipe_enable = 1'b0;
        bus.fs          = 5'd0;
        bus.ft          = 5'd0;
        bus.use_fs      = 1'b0;
        bus.use_ft      = 1'b0;

        // reset held with busy inputs: outputs must stay quiet
        step(0, 1, 5'd3, 1, 5'd3, 5'd3, 1, 1);
        step(0, 1, 5'd7, 1, 5'd0, 5'd0, 0, 0);
        idle(2);

        // basic divide to f5
        step(1, 1, 5'd5, 1, 5'd0, 5'd0, 0, 0);
        idle(14);

        // frozen drain: pipe_enable low on the first two drain cycles
        step(1, 1, 5'd5, 1, 5'd0, 5'd0, 0, 0);
        idle(8);
        step(1, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
        step(1, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
        idle(6);

        // RAW hazard on fs during drain, then an unrelated source
        step(1, 1, 5'd5, 1, 5'd0, 5'd0, 0, 0);
        idle(8);
        step(1, 0, 5'd0, 1, 5'd5, 5'd0, 1, 0);
        step(1, 0, 5'd0, 1, 5'd6, 5'd0, 1, 0);
        step(1, 0, 5'd0, 1, 5'd0, 5'd5, 0, 1);
        idle(4);

        // back-to-back: second divide to f9 held in decode
        step(1, 1, 5'd5, 1, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 5'd9, 1, 5'd0, 5'd0, 0, 0);
        idle(14);

        // reset mid-iteration abandons the divide
        step(1, 1, 5'd12, 1, 5'd0, 5'd0, 0, 0);
        idle(3);
        step(0, 1, 5'd4, 1, 5'd12, 5'd12, 1, 1);
        idle(16);

        // blocked launch on a frozen pipe
        step(1, 1, 5'd8, 0, 5'd0, 5'd0, 0, 0);
        step(1, 1, 5'd8, 0, 5'd0, 5'd0, 0, 0);
        idle(2);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            r_fs = ($urandom_range(0, 1) == 0) ? fd_m : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 4) != 0),
                 r_fs,
                 ($urandom_range(0, 3) == 0) ? fd_m : 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        idle(40);
        @(negedge clock);
        #1;
        chk("exp_q_empty", 5'(exp_q.size()), 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
